// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester handshakes, response channel and multiplier-side signals of mult_arbiter.
interface mult_arbiter_if #(parameter int M = 8, parameter int N = 16);
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [M-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_p;
    logic         busy, mul_ea, mul_eb;
    logic [M-1:0] mul_dataA, mul_dataB;
    logic [N-1:0] mul_p;
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready, mul_p,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy,
               mul_ea, mul_eb, mul_dataA, mul_dataB
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready, mul_p,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy,
               mul_ea, mul_eb, mul_dataA, mul_dataB
    );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one fixed-latency multiplier between two requesters,
// one multiplication in flight, result returned over a valid/ready channel tagged with the id.
module mult_arbiter #(
    parameter int M   = 8,
    parameter int N   = 16,
    parameter int LAT = 4
) (
    input logic           clk,
    input logic           rst_n,
    mult_arbiter_if.slave bus
);
    localparam int CW = $clog2(LAT + 1);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPT, RESP} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [M-1:0]  opa, opb;
    logic [N-1:0]  p_q;
    logic          id, last, gnt0, gnt1;
    // requester 1 wins when alone, or on contention when requester 0 was granted last
    always_comb begin
        gnt1 = bus.req1_valid && (!bus.req0_valid || !last);
        gnt0 = bus.req0_valid && !gnt1;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (gnt0 || gnt1) ? LOAD : IDLE;
            LOAD:    state_nx = WAIT;
            WAIT:    state_nx = (cnt == CW'(LAT - 1)) ? CAPT : WAIT;
            CAPT:    state_nx = RESP;
            RESP:    state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            p_q   <= '0;
            id    <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (state == IDLE && (gnt0 || gnt1)) begin
                opa  <= gnt1 ? bus.req1_a : bus.req0_a;
                opb  <= gnt1 ? bus.req1_b : bus.req0_b;
                id   <= gnt1;
                last <= gnt1;
            end
            if (state == CAPT) p_q <= bus.mul_p;
        end
    end
    // ready is gated by rst_n so it drops with the asynchronous reset, not at the next edge
    assign bus.req0_ready = rst_n && (state == IDLE) && gnt0;
    assign bus.req1_ready = rst_n && (state == IDLE) && gnt1;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = id;
    assign bus.rsp_p      = p_q;
    assign bus.busy       = (state != IDLE);
    assign bus.mul_ea     = (state == LOAD);
    assign bus.mul_eb     = (state == LOAD);
    assign bus.mul_dataA  = opa;
    assign bus.mul_dataB  = opb;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and randomized checks of mult_arbiter against a round-robin
// reference model, with a behavioural fixed-latency multiplier standing in for adder_tree.
module tb_mult_arbiter;
    localparam int M = 8, N = 16, LAT = 4;
    logic clk, rst_n;
    int tests = 0, fails = 0;
    bit last_gnt = 1'b1;
    mult_arbiter_if #(.M(M), .N(N)) bus ();
    mult_arbiter #(.M(M), .N(N), .LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier: product of the operands loaded at an EA/EB edge appears LAT cycles later
    logic [N-1:0] pipe [LAT+1];
    always @(posedge clk) begin
        pipe[0] <= (bus.mul_ea && bus.mul_eb) ? N'(bus.mul_dataA) * N'(bus.mul_dataB) : 16'hdead;
        for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mul_p = pipe[LAT];

    logic [38:0] outs;
    assign outs = {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.busy,
                   bus.mul_ea, bus.mul_eb, bus.mul_dataA, bus.mul_dataB};

    function automatic bit pick(bit v0, bit v1);
        if (v0 && v1) return !last_gnt;
        return v1;
    endfunction

    task automatic issue(input bit r, input logic [M-1:0] a, input logic [M-1:0] b, output bit ok);
        ok = 1'b0;
        if (r) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; end
        else   begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; end
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (r ? bus.req1_ready : bus.req0_ready) ok = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        if (r) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [N-1:0] p, output logic id, output int waited,
                            output int ea_cnt, output int idle_cnt, output bit ok);
        ok = 1'b0; p = '0; id = 1'b0; waited = 0; ea_cnt = 0; idle_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.mul_ea && bus.mul_eb) ea_cnt++;
            if (!bus.busy) idle_cnt++;
            if (bus.rsp_valid) begin ok = 1'b1; p = bus.rsp_p; id = bus.rsp_id; break; end
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic serve(input bit v0, input bit v1, input logic [M-1:0] a0, input logic [M-1:0] b0,
                         input logic [M-1:0] a1, input logic [M-1:0] b1, input bit rnd,
                         output logic [2*N-1:0] ps, output logic [1:0] ids, output int n, output int bad);
        bit p0, p1, g0, g1, hold, hid;
        logic [N-1:0] hp;
        int want;
        p0 = v0; p1 = v1; hold = 1'b0; hid = 1'b0; hp = '0;
        want = int'(v0) + int'(v1);
        n = 0; bad = 0; ps = '0; ids = '0;
        bus.req0_a = a0; bus.req0_b = b0; bus.req1_a = a1; bus.req1_b = b1;
        for (int i = 0; i < 300 && (p0 || p1 || n < want); i++) begin
            bus.req0_valid = p0;
            bus.req1_valid = p1;
            bus.rsp_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            g0 = bus.req0_ready;
            g1 = bus.req1_ready;
            if ((g0 && !p0) || (g1 && !p1) || (g0 && g1)) bad++;
            if (hold && (!bus.rsp_valid || bus.rsp_p !== hp || bus.rsp_id !== hid)) bad++;
            hold = bus.rsp_valid && !bus.rsp_ready;
            hp   = bus.rsp_p;
            hid  = bus.rsp_id;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (n < want) begin ps[n*N +: N] = bus.rsp_p; ids[n] = bus.rsp_id; n++; end
                else bad++;
            end
            @(posedge clk);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit ok, ok2;
        logic [N-1:0] p;
        logic id;
        int w, ea, idl;
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.req0_a = 8'd1; bus.req0_b = 8'd2; bus.req1_a = 8'd3; bus.req1_b = 8'd4;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL reset_state: got %h expected 0", outs); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 8'd5, 8'd9, ok);
        repeat (2) @(negedge clk);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (!ok || outs !== '0) begin
            fails++; $display("FAIL async_reset_mid_wait: got %h (grant %0d) expected 0", outs, ok);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_gnt = 1'b1;
        bus.rsp_ready = 1'b1;
        issue(1'b0, 8'd13, 8'd11, ok);
        wait_rsp(p, id, w, ea, idl, ok2);
        tests++;
        if (!ok || !ok2 || p !== 16'd143 || id !== 1'b0 || w != 6) begin
            fails++; $display("FAIL post_reset_result: got p=%0d id=%0d lat=%0d expected p=143 id=0 lat=6", p, id, w);
        end
        @(negedge clk);
        last_gnt = 1'b0;
    endtask

    task automatic test_single();
        bit ok, ok2;
        logic [N-1:0] p;
        logic id;
        int w, ea, idl;
        bus.rsp_ready = 1'b1;
        issue(1'b0, 8'd200, 8'd100, ok);
        wait_rsp(p, id, w, ea, idl, ok2);
        tests++;
        if (!ok || !ok2 || w != 6) begin
            fails++; $display("FAIL single_latency: got %0d cycles (ok %0d/%0d) expected 6", w, ok, ok2);
        end
        tests++;
        if (p !== 16'd20000 || id !== 1'b0) begin
            fails++; $display("FAIL single_product: got p=%0d id=%0d expected p=20000 id=0", p, id);
        end
        tests++;
        if (ea != 1 || idl != 0) begin
            fails++; $display("FAIL single_strobe_busy: got ea_cycles=%0d idle=%0d expected 1 and 0", ea, idl);
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            fails++; $display("FAIL single_idle: got busy=%0d rsp_valid=%0d expected 0 0", bus.busy, bus.rsp_valid);
        end
        last_gnt = 1'b0;
    endtask

    task automatic test_contention();
        logic [2*N-1:0] ps;
        logic [1:0] ids;
        int n, bad;
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        serve(1'b1, 1'b1, 8'd255, 8'd255, 8'd3, 8'd7, 1'b0, ps, ids, n, bad);
        tests++;
        if (n != 2 || bad != 0 || ids !== 2'b10 || ps !== {16'd21, 16'd65025}) begin
            fails++; $display("FAIL contention_first: got n=%0d bad=%0d ids=%b ps=%h expected 2 0 10 0015fe01", n, bad, ids, ps);
        end
        serve(1'b1, 1'b0, 8'd2, 8'd2, 8'd0, 8'd0, 1'b0, ps, ids, n, bad);
        tests++;
        if (n != 1 || bad != 0 || ids[0] !== 1'b0 || ps[N-1:0] !== 16'd4) begin
            fails++; $display("FAIL contention_single: got n=%0d id=%0d p=%0d expected 1 0 4", n, ids[0], ps[N-1:0]);
        end
        serve(1'b1, 1'b1, 8'd6, 8'd7, 8'd8, 8'd9, 1'b0, ps, ids, n, bad);
        tests++;
        if (n != 2 || bad != 0 || ids !== 2'b01 || ps !== {16'd42, 16'd72}) begin
            fails++; $display("FAIL contention_second: got n=%0d bad=%0d ids=%b ps=%h expected 2 0 01 002a0048", n, bad, ids, ps);
        end
        last_gnt = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok, ok2;
        logic [N-1:0] p;
        logic id;
        int w, ea, idl;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 8'd12, 8'd34, ok);
        bus.req1_valid = 1'b1; bus.req1_a = 8'd9; bus.req1_b = 8'd9;
        wait_rsp(p, id, w, ea, idl, ok2);
        tests++;
        if (!ok || !ok2) begin fails++; $display("FAIL bp_timeout: got ok=%0d/%0d expected 1/1", ok, ok2); end
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 16'd408 || bus.rsp_id !== 1'b0 || bus.req1_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got valid=%0d p=%0d id=%0d req1_ready=%0d expected 1 408 0 0",
                         i, bus.rsp_valid, bus.rsp_p, bus.rsp_id, bus.req1_ready);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (bus.req1_ready !== 1'b1) begin fails++; $display("FAIL bp_next_grant: got req1_ready=%0d expected 1", bus.req1_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_rsp(p, id, w, ea, idl, ok2);
        tests++;
        if (!ok2 || p !== 16'd81 || id !== 1'b1) begin
            fails++; $display("FAIL bp_second: got p=%0d id=%0d expected p=81 id=1", p, id);
        end
        @(negedge clk);
        last_gnt = 1'b1;
    endtask

    task automatic test_edge();
        bit ok, ok2;
        logic [N-1:0] p;
        logic id;
        int w, ea, idl;
        bus.rsp_ready = 1'b1;
        issue(1'b0, 8'd0, 8'd255, ok);
        wait_rsp(p, id, w, ea, idl, ok2);
        tests++;
        if (!ok || !ok2 || p !== 16'd0 || id !== 1'b0 || idl != 0) begin
            fails++; $display("FAIL edge_zero: got p=%0d id=%0d idle=%0d expected 0 0 0", p, id, idl);
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL edge_idle_busy: got %0d expected 0", bus.busy); end
        issue(1'b1, 8'd1, 8'd1, ok);
        wait_rsp(p, id, w, ea, idl, ok2);
        tests++;
        if (!ok || !ok2 || p !== 16'd1 || id !== 1'b1 || idl != 0) begin
            fails++; $display("FAIL edge_one: got p=%0d id=%0d idle=%0d expected 1 1 0", p, id, idl);
        end
        @(negedge clk);
        last_gnt = 1'b1;
    endtask

    task automatic test_random();
        logic [2*N-1:0] ps;
        logic [1:0] ids, pat;
        logic [M-1:0] a0, b0, a1, b1;
        logic [N-1:0] e;
        bit v0, v1, first, eid;
        int n, bad, want, ops, rounds;
        ops = 0; rounds = 0;
        while (ops < 20 && rounds < 40) begin
            pat = 2'($urandom_range(1, 3));
            v0 = pat[0]; v1 = pat[1];
            a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            want = int'(v0) + int'(v1);
            first = pick(v0, v1);
            serve(v0, v1, a0, b0, a1, b1, 1'b1, ps, ids, n, bad);
            tests++;
            if (n != want || bad != 0) begin
                fails++; $display("FAIL rand_protocol[%0d]: got n=%0d bad=%0d expected n=%0d bad=0", rounds, n, bad, want);
            end
            for (int k = 0; k < n; k++) begin
                eid = (k == 0) ? first : !first;
                e = eid ? N'(a1) * N'(b1) : N'(a0) * N'(b0);
                tests++;
                if (ps[k*N +: N] !== e || ids[k] !== eid) begin
                    fails++; $display("FAIL rand_result[%0d.%0d]: got p=%0d id=%0d expected p=%0d id=%0d",
                                      rounds, k, ps[k*N +: N], ids[k], e, eid);
                end
            end
            last_gnt = (v0 && v1) ? !first : first;
            ops += want;
            rounds++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_edge();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
